// File: rtl/cache_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cache_arbiter                                                |
// | Description : Shares one physical-memory line port between the I-cache and |
// |               the D-cache. One grant at a time; the winner's request is    |
// |               latched and held stable until pmem_resp.                     |
// |               Optional macro CACHE_ARB_RR_EN: round-robin tie-break        |
// |               (default build: D-cache wins every tie).                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cache_arbiter #(
  parameter int s_line = 256,
  parameter int s_addr = 32
) (
  input  logic              clk,
  input  logic              reset,
  // I-cache side
  input  logic              i_pmem_read,
  input  logic              i_pmem_write,
  input  logic [s_addr-1:0] i_pmem_address,
  input  logic [s_line-1:0] i_pmem_wdata,
  output logic              i_pmem_resp,
  output logic [s_line-1:0] i_pmem_rdata,
  // D-cache side
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [s_addr-1:0] d_pmem_address,
  input  logic [s_line-1:0] d_pmem_wdata,
  output logic              d_pmem_resp,
  output logic [s_line-1:0] d_pmem_rdata,
  // Physical memory side
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [s_addr-1:0] pmem_address,
  output logic [s_line-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [s_line-1:0] pmem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [s_addr-1:0] addr_q, addr_d;
  logic [s_line-1:0] wdata_q, wdata_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              i_req_w, d_req_w, grant_d_w;

`ifdef CACHE_ARB_RR_EN
  // 1 = D-cache was granted last, 0 = I-cache (reset value).
  logic              last_grant_q, last_grant_d;
`endif

  assign i_req_w = i_pmem_read | i_pmem_write;
  assign d_req_w = d_pmem_read | d_pmem_write;

  // Arbitration decision: does the D-cache win the grant this cycle.
  always_comb begin
`ifdef CACHE_ARB_RR_EN
    // On a tie the port that was not granted last wins.
    grant_d_w = d_req_w & (~i_req_w | ~last_grant_q);
`else
    grant_d_w = d_req_w;
`endif
  end

  // Next-state logic: grant from IDLE, capture the winner, release on resp.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
`ifdef CACHE_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_d_w) begin
          state_d = SERVE_D;
          addr_d  = d_pmem_address;
          wdata_d = d_pmem_wdata;
          wr_d    = d_pmem_write;
          rd_d    = d_pmem_read & ~d_pmem_write;  // write dominates
`ifdef CACHE_ARB_RR_EN
          last_grant_d = 1'b1;
`endif
        end else if (i_req_w) begin
          state_d = SERVE_I;
          addr_d  = i_pmem_address;
          wdata_d = i_pmem_wdata;
          wr_d    = i_pmem_write;
          rd_d    = i_pmem_read & ~i_pmem_write;
`ifdef CACHE_ARB_RR_EN
          last_grant_d = 1'b0;
`endif
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and request-latch registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
`ifdef CACHE_ARB_RR_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
`ifdef CACHE_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Memory-facing outputs come only from the latch and the state register.
  assign pmem_read    = (state_q != IDLE) & rd_q;
  assign pmem_write   = (state_q != IDLE) & wr_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  // Response routed only to the port being served; read data broadcast.
  assign i_pmem_resp  = (state_q == SERVE_I) & pmem_resp;
  assign d_pmem_resp  = (state_q == SERVE_D) & pmem_resp;
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_cache_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cache_arbiter                                             |
// | Description : Directed self-checking bench for cache_arbiter.              |
// |               Expectations follow CACHE_ARB_RR_EN when it is defined.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_cache_arbiter;

  localparam int c_line = 256;
  localparam int c_addr = 32;
  localparam int c_lat  = 3;   // memory answers this many cycles after the request rises

  logic              clk;
  logic              reset;
  logic              i_pmem_read, i_pmem_write;
  logic [c_addr-1:0] i_pmem_address;
  logic [c_line-1:0] i_pmem_wdata;
  logic              i_pmem_resp;
  logic [c_line-1:0] i_pmem_rdata;
  logic              d_pmem_read, d_pmem_write;
  logic [c_addr-1:0] d_pmem_address;
  logic [c_line-1:0] d_pmem_wdata;
  logic              d_pmem_resp;
  logic [c_line-1:0] d_pmem_rdata;
  logic              pmem_read, pmem_write;
  logic [c_addr-1:0] pmem_address;
  logic [c_line-1:0] pmem_wdata;
  logic              pmem_resp;
  logic [c_line-1:0] pmem_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  bit mem_auto = 1'b0;
  int mem_cnt  = 0;

  cache_arbiter #(.s_line(c_line), .s_addr(c_addr)) dut (
    .clk(clk), .reset(reset),
    .i_pmem_read(i_pmem_read), .i_pmem_write(i_pmem_write),
    .i_pmem_address(i_pmem_address), .i_pmem_wdata(i_pmem_wdata),
    .i_pmem_resp(i_pmem_resp), .i_pmem_rdata(i_pmem_rdata),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_resp(d_pmem_resp), .d_pmem_rdata(d_pmem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: memory model reacts 1 time unit after the edge, checks happen at +2.
  task automatic tick();
    @(posedge clk);
    #1;
    if (mem_auto) begin
      if (pmem_read | pmem_write) begin
        pmem_resp = (mem_cnt == c_lat);
        mem_cnt   = mem_cnt + 1;
      end else begin
        pmem_resp = 1'b0;
        mem_cnt   = 0;
      end
    end
    #1;
  endtask

  // Wait (bounded) for the selected port's resp; returns the number of clocks waited.
  task automatic wait_resp(input bit want_d, input string tag, output int n);
    n = 0;
    while (!(want_d ? d_pmem_resp : i_pmem_resp) && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_resp_seen"}, 256'(want_d ? d_pmem_resp : i_pmem_resp), 256'(1));
    check({tag, "_other_resp"}, 256'(want_d ? i_pmem_resp : d_pmem_resp), 256'(0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_pmem_read = 1'b0; i_pmem_write = 1'b0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    pmem_resp = 1'b0;
    mem_cnt = 0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  int n;

  initial begin
    i_pmem_address = '0; i_pmem_wdata = '0;
    d_pmem_address = '0; d_pmem_wdata = '0;
    pmem_rdata = {32{8'hA5}};
    do_reset();

    // Reset values
    check("rst_pmem_read",  256'(pmem_read), 256'(0));
    check("rst_pmem_write", 256'(pmem_write), 256'(0));
    check("rst_resps",      256'({i_pmem_resp, d_pmem_resp}), 256'(0));
    check("rst_address",    256'(pmem_address), 256'(0));
    check("rst_wdata",      pmem_wdata, 256'(0));
    check("rst_rdata_bcast", {i_pmem_rdata ^ {32{8'hA5}}} | {d_pmem_rdata ^ {32{8'hA5}}}, 256'(0));
    mem_auto = 1'b1;

    // Single I read at 0x40
    i_pmem_read = 1'b1; i_pmem_address = 32'h40;
    #1 check("ird_not_yet", 256'(pmem_read), 256'(0));
    tick();
    check("ird_pmem_read", 256'(pmem_read), 256'(1));
    check("ird_address",   256'(pmem_address), 256'h40);
    wait_resp(1'b0, "ird", n);
    check("ird_latency",   256'(n), 256'(c_lat));
    check("ird_rdata",     i_pmem_rdata, {32{8'hA5}});
    i_pmem_read = 1'b0;
    tick();
    check("ird_resp_pulse", 256'(i_pmem_resp), 256'(0));
    check("ird_read_drop",  256'(pmem_read), 256'(0));

    // Single D write at 0x1000
    d_pmem_write = 1'b1; d_pmem_address = 32'h1000; d_pmem_wdata = 256'h1234;
    tick();
    check("dwr_pmem_write", 256'(pmem_write), 256'(1));
    check("dwr_pmem_read",  256'(pmem_read), 256'(0));
    check("dwr_wdata",      pmem_wdata, 256'h1234);
    check("dwr_address",    256'(pmem_address), 256'h1000);
    wait_resp(1'b1, "dwr", n);
    d_pmem_write = 1'b0;
    tick();

    // Simultaneous I 0x80 / D 0x2000 after reset: D first, then I
    do_reset();
    i_pmem_read = 1'b1; i_pmem_address = 32'h80;
    d_pmem_read = 1'b1; d_pmem_address = 32'h2000;
    tick();
    check("sim_first_addr", 256'(pmem_address), 256'h2000);
    wait_resp(1'b1, "sim_d", n);
    d_pmem_read = 1'b0;
    tick();
    check("sim_idle_gap", 256'(pmem_read), 256'(0));
    tick();
    check("sim_second_rd",   256'(pmem_read), 256'(1));
    check("sim_second_addr", 256'(pmem_address), 256'h80);
    wait_resp(1'b0, "sim_i", n);
    i_pmem_read = 1'b0;
    tick();

    // Two consecutive ties: D, I (alone), D (tie), I
    do_reset();
    i_pmem_read = 1'b1; i_pmem_address = 32'h100;
    d_pmem_read = 1'b1; d_pmem_address = 32'h3000;
    tick();
    check("tie_g1", 256'(pmem_address), 256'h3000);
    wait_resp(1'b1, "tie_g1", n);
    d_pmem_read = 1'b0;
    tick();
    tick();
    check("tie_g2", 256'(pmem_address), 256'h100);
    d_pmem_read = 1'b1; d_pmem_address = 32'h3100;
    wait_resp(1'b0, "tie_g2", n);
    i_pmem_address = 32'h140;          // I re-requests at once: tie in next IDLE
    tick();
    tick();
    check("tie_g3", 256'(pmem_address), 256'h3100);
    wait_resp(1'b1, "tie_g3", n);
    d_pmem_read = 1'b0;
    tick();
    tick();
    check("tie_g4", 256'(pmem_address), 256'h140);
    wait_resp(1'b0, "tie_g4", n);
    i_pmem_read = 1'b0;
    tick();

    // Tie right after a D grant: the policy decides who follows
    do_reset();
    i_pmem_read = 1'b1; i_pmem_address = 32'h200;
    d_pmem_read = 1'b1; d_pmem_address = 32'h4000;
    tick();
    check("pol_g1", 256'(pmem_address), 256'h4000);
    wait_resp(1'b1, "pol_g1", n);
    d_pmem_address = 32'h4100;         // D re-requests at once
    tick();
    tick();
`ifdef CACHE_ARB_RR_EN
    check("pol_g2", 256'(pmem_address), 256'h200);
`else
    check("pol_g2", 256'(pmem_address), 256'h4100);
`endif
    do_reset();

    // Address change mid-transaction is ignored
    i_pmem_read = 1'b1; i_pmem_address = 32'h40;
    tick();
    check("chg_addr0", 256'(pmem_address), 256'h40);
    i_pmem_address = 32'h60;
    tick();
    check("chg_addr1", 256'(pmem_address), 256'h40);
    wait_resp(1'b0, "chg", n);
    check("chg_addr_resp", 256'(pmem_address), 256'h40);
    i_pmem_read = 1'b0;
    tick();

    // Reset two cycles into a D read, then a stray pmem_resp in IDLE
    d_pmem_read = 1'b1; d_pmem_address = 32'h5000;
    tick();
    tick();
    check("rmt_reading", 256'(pmem_read), 256'(1));
    mem_auto = 1'b0;
    pmem_resp = 1'b0;
    reset = 1'b1;
    d_pmem_read = 1'b0;
    tick();
    reset = 1'b0;
    check("rmt_read_drop", 256'(pmem_read), 256'(0));
    check("rmt_no_dresp",  256'(d_pmem_resp), 256'(0));
    pmem_resp = 1'b1;
    #1 check("stray_resps", 256'({i_pmem_resp, d_pmem_resp}), 256'(0));
    tick();
    check("stray_still_idle", 256'({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}), 256'(0));
    pmem_resp = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
